// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundles the instruction-memory read port, the downstream
//                instruction-register handshake and the control-path redirect
//                of the MISC-V fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
    // Instruction memory read port
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    // Downstream instruction-register handshake
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ack;

    // Branch / jump redirect from the control path
    logic        redirect;
    logic [15:0] redirect_pc;

    // The fetch stage itself
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata,
        output instr_out,
        output instr_pc,
        output instr_valid,
        input  instr_ack,
        input  redirect,
        input  redirect_pc
    );

    // Memory, instruction register and control path seen together
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata,
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        output instr_ack,
        output redirect,
        output redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Holds the PC, reads instruction
//                memory over a req/ready handshake and presents each word with
//                its PC to the instruction register under valid/ack.
//                Redirects from the control path win over everything.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  wire           CLK,
    input  wire           reset,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_mem_req;
    logic        r_instr_valid;

    // Next PC after an accepted fetch; wraps modulo 2^16 by construction.
    logic [15:0] w_pc_next;
    assign w_pc_next = r_pc + PC_STEP;

    // State, PC, captured instruction and registered handshake outputs.
    // r_mem_req / r_instr_valid always track the state being entered so they
    // are glitch-free and drop at once on an asynchronous reset.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state       <= ST_START;
            r_pc          <= RESET_PC;
            r_instr       <= 16'h0000;
            r_instr_pc    <= 16'h0000;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
        end else if (bus.redirect) begin
            // Redirect discards any same-cycle memory data and any pending
            // instruction; the new target is requested next cycle.
            r_pc          <= bus.redirect_pc;
            r_state       <= ST_FETCH;
            r_mem_req     <= 1'b1;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_state       <= ST_FETCH;
                    r_mem_req     <= 1'b1;
                    r_instr_valid <= 1'b0;
                end
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        r_instr       <= bus.mem_rdata;
                        r_instr_pc    <= r_pc;
                        r_pc          <= w_pc_next;
                        r_state       <= ST_HOLD;
                        r_mem_req     <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.instr_ack) begin
                        r_state       <= ST_FETCH;
                        r_mem_req     <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_START;
                    r_mem_req     <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_pc;
    assign bus.instr_out   = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;

endmodule
`default_nettype wire
